lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Two-port arbiter that shares the single LC-3 memory port (address, write data, read data, write enable) between the processor core and a second bus master (program loader / DMA engine). It accepts one transaction at a time from either requester, registers it onto the memory port, and returns read data or write acknowledgement with fixed latency. Arbitration is round-robin, with a bounded lock so a loader burst cannot starve the core.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_LOCK, 8, max consecutive grants to one locked requester while the other is requesting (>=1)

Ports (x = 0 core, x = 1 loader):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_x  in  1  transaction request, held until gnt_x
- lock_x  in  1  keep grant for the next transaction (sampled with req_x)
- we_x  in  1  1 = write, 0 = read
- addr_x  in  ADDR_W  transaction address
- wdata_x  in  DATA_W  write data
- gnt_x  out  1  request accepted this cycle (combinational)
- rvalid_x  out  1  response cycle; read data valid / write done
- rdata_x  out  DATA_W  read data, meaningful only with rvalid_x
- memory_addr  out  ADDR_W  registered memory address
- memory_din  out  DATA_W  registered memory write data
- memWE  out  1  registered write enable, one-cycle pulse
- memory_dout  in  DATA_W  memory read data, valid one cycle after address presented

## Operation
- States: IDLE, ACCESS, RESP. Accept possible in IDLE or RESP; never in ACCESS.
- Accept cycle: selected requester sees gnt_x=1; addr/wdata/we captured. Next state ACCESS.
- ACCESS: memory_addr/memory_din hold captured values; memWE = captured we. Next state RESP.
- RESP: rvalid_x=1 for the owner; rdata_x = memory_dout (pass-through; writes return memory_dout but it is ignored). If a request is accepted in RESP, next state ACCESS; else IDLE.
- memory_addr and memory_din retain last value outside ACCESS; memWE is 0 outside ACCESS.
- rdata_x of the non-owner and rvalid of the non-owner are 0.
- Selection: one requester -> it wins. Both -> winner is the one not granted last (last-grant pointer), unless lock rule applies.
- Lock: if previous grant had lock set and the same requester requests again, it keeps priority; lock_count increments per locked grant. When lock_count reaches MAX_LOCK and the other port is requesting, the other port wins and lock_count clears. lock_count clears on any grant without lock or on owner change.
- Only one gnt_x high per cycle; gnt never asserted without the matching req.
- Requester must hold req/we/addr/wdata stable until gnt; dropping req before gnt withdraws the request with no side effect.

## Timing
- Reset (rst high at rising edge): state IDLE, last-grant pointer = 1 (core wins first tie), lock_count 0, memory_addr 0, memory_din 0, memWE 0, rvalid_0/1 0. gnt_x is 0 while rst is high.
- Reset mid-transaction: transaction abandoned; no rvalid, memWE 0 from next cycle.
- Latency: accept at cycle t -> memory port driven cycle t+1 -> rvalid at t+2.
- Throughput: one transaction per 2 cycles (next accept overlaps RESP).
- Write committed at rising edge ending cycle t+1.
- Read-after-write to the same address by back-to-back transactions returns new data.

## Test plan
- Reset: hold rst 2 cycles with both req high -> no gnt, memWE 0, memory_addr 0; first cycle after rst release grants port 0.
- Single read: core reads 0x3000 holding 0xBEEF -> gnt_0 at t, memory_addr=0x3000 at t+1, rvalid_0 and rdata_0=0xBEEF at t+2, rvalid_1 stays 0.
- Write then read: loader writes 0x1234 to 0x4000, then reads 0x4000 -> memWE pulse exactly at t+1, read returns 0x1234; gnts 2 cycles apart.
- Round-robin: both request continuously, no lock -> grants alternate 0,1,0,1 every 2 cycles.
- Lock bound: loader requests with lock held, core also requesting, MAX_LOCK=8 -> after any initial core grant, loader gets 8 consecutive grants, then core granted.
- Reset mid-op: assert rst during ACCESS of a write -> memWE deasserted next cycle, no rvalid, state IDLE.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC-3 memory port between the core (0)
// and a loader/DMA master (1) with round-robin arbitration and bounded lock.
module lc3_mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_0,
   input  logic              lock_0,
   input  logic              we_0,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [DATA_W-1:0] wdata_0,
   output logic              gnt_0,
   output logic              rvalid_0,
   output logic [DATA_W-1:0] rdata_0,
   input  logic              req_1,
   input  logic              lock_1,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_1,
   output logic              gnt_1,
   output logic              rvalid_1,
   output logic [DATA_W-1:0] rdata_1,
   output logic [ADDR_W-1:0] memory_addr,
   output logic [DATA_W-1:0] memory_din,
   output logic              memWE,
   input  logic [DATA_W-1:0] memory_dout
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              lock_q, lock_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;

   logic              sel;
   logic              accept;
   logic              lock_hold;
   logic              sel_lock;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // A locked owner keeps priority until it has used MAX_LOCK grants.
   always_comb begin
      lock_hold = lock_q && (lock_cnt_q < CNT_MAX);
      sel       = req_1;
      if (req_0 && req_1) begin
         sel = lock_hold ? last_q : ~last_q;
      end
      accept    = !rst && (state_q != ACCESS) && (req_0 || req_1);
      sel_lock  = sel ? lock_1  : lock_0;
      sel_we    = sel ? we_1    : we_0;
      sel_addr  = sel ? addr_1  : addr_0;
      sel_wdata = sel ? wdata_1 : wdata_0;
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;

      unique case (state_q)
         IDLE:    state_d = accept ? ACCESS : IDLE;
         ACCESS:  state_d = RESP;
         RESP:    state_d = accept ? ACCESS : IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         owner_d    = sel;
         last_d     = sel;
         lock_d     = sel_lock;
         mem_addr_d = sel_addr;
         mem_din_d  = sel_wdata;
         mem_we_d   = sel_we;
         if (!sel_lock) begin
            lock_cnt_d = '0;
         end else if (lock_q && (sel == last_q)) begin
            lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q
                                                 : lock_cnt_q + CNT_W'(1);
         end else begin
            lock_cnt_d = CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         lock_q     <= 1'b0;
         lock_cnt_q <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_cnt_q <= lock_cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
      end
   end

   assign gnt_0       = accept && !sel;
   assign gnt_1       = accept && sel;
   assign rvalid_0    = (state_q == RESP) && !owner_q;
   assign rvalid_1    = (state_q == RESP) && owner_q;
   assign rdata_0     = rvalid_0 ? memory_dout : '0;
   assign rdata_1     = rvalid_1 ? memory_dout : '0;
   assign memory_addr = mem_addr_q;
   assign memory_din  = mem_din_q;
   assign memWE       = mem_we_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed and random traffic on both ports, checked
// every cycle against a transaction-level arbitration and memory model.
module tb_lc3_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int ML = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req [2];
   logic          lock [2];
   logic          we [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
   logic [DW-1:0] rdata_0, rdata_1;
   logic [AW-1:0] memory_addr;
   logic [DW-1:0] memory_din;
   logic          memWE;
   logic [DW-1:0] memory_dout = '0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit gseen [2];

   typedef struct {
      int        cyc;
      bit        own;
      bit        we;
      bit [15:0] a;
      bit [15:0] d;
   } txn_t;

   txn_t      hist [$];
   bit [15:0] ref_mem [65536];
   bit        ref_wr [65536];
   bit [15:0] bus_mem [65536];
   bit        bus_wr [65536];
   bit        m_last = 1'b1;
   bit        m_lockp = 1'b0;
   int        m_run = 0;
   bit [15:0] m_maddr = '0;

   lc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
      .clk(clk), .rst(rst),
      .req_0(req[0]), .lock_0(lock[0]), .we_0(we[0]),
      .addr_0(addr[0]), .wdata_0(wdata[0]),
      .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
      .req_1(req[1]), .lock_1(lock[1]), .we_1(we[1]),
      .addr_1(addr[1]), .wdata_1(wdata[1]),
      .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
      .memory_addr(memory_addr), .memory_din(memory_din),
      .memWE(memWE), .memory_dout(memory_dout)
   );

   always #5 clk = ~clk;

   function automatic bit [15:0] seed_val(input bit [15:0] a);
      return (a == 16'h3000) ? 16'hBEEF : ((a ^ 16'h5A5A) + 16'h0101);
   endfunction

   // Synchronous memory: one-cycle read latency, write on memWE.
   always @(posedge clk) begin
      if (memWE) begin
         bus_mem[memory_addr] <= memory_din;
         bus_wr[memory_addr]  <= 1'b1;
      end
      memory_dout <= bus_wr[memory_addr] ? bus_mem[memory_addr]
                                         : seed_val(memory_addr);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit [15:0] ref_rd(input bit [15:0] a);
      return ref_wr[a] ? ref_mem[a] : seed_val(a);
   endfunction

   task automatic eval();
      bit        busy, acc, w, ex_we, lw;
      bit        ex_rv [2];
      bit        rd_ok [2];
      bit [15:0] ex_rd [2];
      bit [15:0] ex_din, wa;
      busy = 0; ex_we = 0; ex_din = '0; wa = '0;
      ex_rv = '{0, 0}; rd_ok = '{1, 1}; ex_rd = '{16'h0, 16'h0};
      foreach (hist[i]) begin
         if (hist[i].cyc == cyc - 1) begin
            busy = 1; ex_we = hist[i].we; ex_din = hist[i].d; wa = hist[i].a;
         end
         if (hist[i].cyc == cyc - 2) begin
            ex_rv[hist[i].own] = 1;
            if (hist[i].we) rd_ok[hist[i].own] = 0;
            else ex_rd[hist[i].own] = ref_rd(hist[i].a);
         end
      end
      acc = !rst && !busy && (req[0] || req[1]);
      if (req[0] && req[1]) w = (m_lockp && m_run < ML) ? m_last : !m_last;
      else w = req[1];

      check("gnt_0", 32'(gnt_0), 32'(acc && !w));
      check("gnt_1", 32'(gnt_1), 32'(acc && w));
      check("rvalid_0", 32'(rvalid_0), 32'(ex_rv[0]));
      check("rvalid_1", 32'(rvalid_1), 32'(ex_rv[1]));
      if (rd_ok[0]) check("rdata_0", 32'(rdata_0), 32'(ex_rd[0]));
      if (rd_ok[1]) check("rdata_1", 32'(rdata_1), 32'(ex_rd[1]));
      check("memWE", 32'(memWE), 32'(ex_we));
      check("mem_addr", 32'(memory_addr), 32'(m_maddr));
      if (ex_we) check("mem_din", 32'(memory_din), 32'(ex_din));
      gseen[0] = gnt_0;
      gseen[1] = gnt_1;

      if (ex_we) begin
         ref_mem[wa] = ex_din;
         ref_wr[wa]  = 1'b1;
      end
      if (acc) begin
         lw = lock[w];
         if (lw) m_run = (w == m_last && m_lockp) ? m_run + 1 : 1;
         else m_run = 0;
         m_last = w; m_lockp = lw; m_maddr = addr[w];
         hist.push_back('{cyc, w, we[w], addr[w], wdata[w]});
      end
      while (hist.size() > 0 && hist[0].cyc < cyc - 1) void'(hist.pop_front());
      if (rst) begin
         hist.delete();
         m_last = 1'b1; m_lockp = 1'b0; m_run = 0; m_maddr = '0;
      end
      cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      eval();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p_req, input int p_lock, input bit drop);
      for (int x = 0; x < 2; x++) begin
         if (req[x] && !gseen[x]) begin
            if (drop && $urandom_range(0, 9) == 0) req[x] = 1'b0;
         end else begin
            req[x]   = $urandom_range(0, 99) < p_req;
            we[x]    = 1'($urandom_range(0, 1));
            addr[x]  = 16'h3000 | 16'($urandom_range(0, 15));
            wdata[x] = 16'($urandom);
            lock[x]  = $urandom_range(0, 99) < p_lock;
         end
      end
   endtask

   task automatic wait_gnt(input int x, input int budget);
      int n;
      step();
      n = 1;
      while (!gseen[x] && n < budget) begin
         step();
         n++;
      end
      check("gnt_wait", 32'(gseen[x]), 32'd1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((req[0] || req[1]) && n < budget) begin
         step();
         for (int x = 0; x < 2; x++) if (gseen[x]) req[x] = 1'b0;
         n++;
      end
      check("drain", 32'(req[0] || req[1]), 32'd0);
      step();
      step();
   endtask

   initial begin
      int run1, runs_done, full_run;
      for (int x = 0; x < 2; x++) begin
         req[x] = 1'b1; lock[x] = 1'b0; we[x] = 1'b0;
         addr[x] = 16'h3000 + 16'(x); wdata[x] = '0;
      end

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check("first_gnt0", 32'(gseen[0]), 32'd1);
      if (gseen[0]) req[0] = 1'b0;
      drain(20);

      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h3000;
      drain(20);

      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h4000; wdata[1] = 16'h1234;
      wait_gnt(1, 20);
      we[1] = 1'b0;
      wait_gnt(1, 3);
      req[1] = 1'b0;
      step();
      step();

      repeat (16) begin
         drive(100, 0, 1'b0);
         step();
      end

      run1 = 0; runs_done = 0; full_run = -1;
      repeat (60) begin
         drive(100, 0, 1'b0);
         lock[0] = 1'b0;
         lock[1] = 1'b1;
         step();
         if (gseen[1]) run1++;
         if (gseen[0]) begin
            if (run1 > 0) begin
               runs_done++;
               if (runs_done == 2) full_run = run1;
            end
            run1 = 0;
         end
      end
      check("lock_run", 32'(full_run), 32'(ML));
      drain(40);

      req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b0;
      addr[1] = 16'h3004; wdata[1] = 16'h7777;
      wait_gnt(1, 20);
      req[1] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_we", 32'(memWE), 32'd0);
      check("rst_mid_rv", 32'(rvalid_1), 32'd0);
      step();
      step();

      repeat (3000) begin
         rst = ($urandom_range(0, 63) == 0);
         drive(60, 25, 1'b1);
         step();
      end
      rst = 1'b0;
      drain(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
